// File: rtl/float_div_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : float_div_seq
// Brief   : Sequential IEEE-754 single-precision divider, radix-2 restoring,
//           one quotient bit per cycle with start/busy/done handshake.
// Rev     : 1.0
// ============================================================================
module float_div_seq #(
    parameter int ITER = 27
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [31:0] float_a,
    input  logic [31:0] float_b,
    input  logic        round_cofig,
    output logic        busy,
    output logic        done,
    output logic [31:0] float_q,
    output logic [1:0]  overflow
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_RND  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [4:0] c_last_iter = 5'(ITER - 1);

    state_t             r_state, w_state_next;
    logic               r_sign, r_rnd;
    logic signed [9:0]  r_exp;
    logic [23:0]        r_mb;
    logic [25:0]        r_rem;
    logic [26:0]        r_q;
    logic [4:0]         r_cnt;
    logic [31:0]        r_res;
    logic [1:0]         r_code;

    logic [7:0]         w_ea, w_eb;
    logic [22:0]        w_fa, w_fb;
    logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_invalid, w_sign_in;
    logic               w_special;
    logic [31:0]        w_spec_res;
    logic [1:0]         w_spec_code;
    logic signed [9:0]  w_exp_in;

    assign w_ea      = float_a[30:23];
    assign w_eb      = float_b[30:23];
    assign w_fa      = float_a[22:0];
    assign w_fb      = float_b[22:0];
    assign w_sign_in = float_a[31] ^ float_b[31];
    assign w_a_zero  = (w_ea == 8'd0);
    assign w_b_zero  = (w_eb == 8'd0);
    assign w_a_inf   = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_b_inf   = (w_eb == 8'hFF) && (w_fb == 23'd0);
    assign w_invalid = ((w_ea == 8'hFF) && (w_fa != 23'd0)) ||
                       ((w_eb == 8'hFF) && (w_fb != 23'd0)) ||
                       (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
    assign w_exp_in  = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;

    // Special operands bypass the iteration and resolve straight to FIN
    always_comb begin
        w_special   = 1'b1;
        w_spec_res  = 32'h7FC0_0000;
        w_spec_code = 2'b11;
        if (w_invalid) begin
            w_spec_res  = 32'h7FC0_0000;
            w_spec_code = 2'b11;
        end else if (w_a_inf) begin
            w_spec_res  = {w_sign_in, 8'hFF, 23'd0};
            w_spec_code = 2'b01;
        end else if (w_b_zero) begin
            w_spec_res  = {w_sign_in, 8'hFF, 23'd0};
            w_spec_code = 2'b11;
        end else if (w_a_zero || w_b_inf) begin
            w_spec_res  = {w_sign_in, 31'd0};
            w_spec_code = 2'b00;
        end else begin
            w_special   = 1'b0;
        end
    end

    logic               w_ge;
    logic [25:0]        w_diff;

    assign w_ge   = (r_rem >= {2'b00, r_mb});
    assign w_diff = w_ge ? (r_rem - {2'b00, r_mb}) : r_rem;

    // Quotient lies in (0.5, 2): one conditional shift normalizes it
    logic [25:0]        w_qn;
    logic signed [9:0]  w_exp_n, w_exp_r;
    logic               w_up;
    logic [23:0]        w_fsum;
    logic [31:0]        w_rnd_res;
    logic [1:0]         w_rnd_code;

    assign w_qn    = r_q[26] ? r_q[25:0] : {r_q[24:0], 1'b0};
    assign w_exp_n = r_q[26] ? r_exp : (r_exp - 10'sd1);
    assign w_up    = ~r_rnd & w_qn[2] & (w_qn[3] | (|w_qn[1:0]) | (|r_rem));
    assign w_fsum  = {1'b0, w_qn[25:3]} + {23'd0, w_up};
    assign w_exp_r = w_exp_n + $signed({9'd0, w_fsum[23]});

    always_comb begin
        w_rnd_res  = {r_sign, w_exp_r[7:0], w_fsum[22:0]};
        w_rnd_code = 2'b00;
        if (w_exp_r >= 10'sd255) begin
            w_rnd_res  = {r_sign, 8'hFF, 23'd0};
            w_rnd_code = 2'b01;
        end else if (w_exp_r <= 10'sd0) begin
            w_rnd_res  = {r_sign, 31'd0};
            w_rnd_code = 2'b10;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = w_special ? S_FIN : S_DIV;
            S_DIV:   if (r_cnt == c_last_iter) w_state_next = S_RND;
            S_RND:   w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sign   <= 1'b0;
            r_rnd    <= 1'b0;
            r_exp    <= '0;
            r_mb     <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_code   <= '0;
            done     <= 1'b0;
            float_q  <= 32'h0;
            overflow <= 2'b00;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_sign <= w_sign_in;
                    r_rnd  <= round_cofig;
                    r_exp  <= w_exp_in;
                    r_mb   <= {1'b1, w_fb};
                    r_rem  <= {3'b001, w_fa};
                    r_q    <= '0;
                    r_cnt  <= '0;
                    r_res  <= w_spec_res;
                    r_code <= w_spec_code;
                end
                S_DIV: begin
                    r_rem <= w_diff << 1;
                    r_q   <= {r_q[25:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_RND: begin
                    r_res  <= w_rnd_res;
                    r_code <= w_rnd_code;
                end
                S_FIN: begin
                    float_q  <= r_res;
                    overflow <= r_code;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_float_div_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_float_div_seq
// Brief   : Scoreboard bench for float_div_seq: directed and random divisions
//           checked against an exact integer-quotient reference model.
// Rev     : 1.0
// ============================================================================
module tb_float_div_seq;
    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic [31:0] float_a, float_b;
    logic        round_cofig;
    logic        busy, done;
    logic [31:0] float_q;
    logic [1:0]  overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    typedef struct {
        logic [31:0] q;
        logic [1:0]  code;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    float_div_seq dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start       (start),
        .float_a     (float_a),
        .float_b     (float_b),
        .round_cofig (round_cofig),
        .busy        (busy),
        .done        (done),
        .float_q     (float_q),
        .overflow    (overflow)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp_v, cycle);
        end
    endtask

    // Exact model: 24-bit quotient plus true remainder decides rounding
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic rc,
                           output logic [31:0] q, output logic [1:0] code, output int lat);
        int     ea, eb, e;
        bit     s, az, bz, ai, bi, an, bn;
        longint ma, mb, num, m, r;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        lat = 1;
        if (an || bn || (az && bz) || (ai && bi)) begin
            q = 32'h7FC00000; code = 2'b11;
        end else if (ai) begin
            q = {s, 8'hFF, 23'h0}; code = 2'b01;
        end else if (bz) begin
            q = {s, 8'hFF, 23'h0}; code = 2'b11;
        end else if (az || bi) begin
            q = {s, 31'h0}; code = 2'b00;
        end else begin
            lat = 29;
            ma  = longint'({1'b1, a[22:0]});
            mb  = longint'({1'b1, b[22:0]});
            e   = ea - eb + 127;
            if (ma >= mb) num = ma << 23;
            else begin
                num = ma << 24;
                e   = e - 1;
            end
            m = num / mb;
            r = num % mb;
            if (!rc && ((2 * r > mb) || ((2 * r == mb) && (m % 2 == 1)))) m = m + 1;
            if (m == (longint'(1) << 24)) begin
                m = longint'(1) << 23;
                e = e + 1;
            end
            if (e >= 255) begin
                q = {s, 8'hFF, 23'h0}; code = 2'b01;
            end else if (e <= 0) begin
                q = {s, 31'h0}; code = 2'b10;
            end else begin
                q = {s, 8'(e), m[22:0]}; code = 2'b00;
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic rc,
                         input logic [31:0] eq, input logic [1:0] ec, input int lat);
        exp_t e;
        int   g;
        g = 0;
        @(negedge sys_clk);
        while (busy && g < 100) begin
            @(negedge sys_clk);
            g++;
        end
        if (busy) check("issue_timeout", 64'(busy), 64'd0);
        float_a     = a;
        float_b     = b;
        round_cofig = rc;
        start       = 1'b1;
        e.q    = eq;
        e.code = ec;
        e.cyc  = cycle + 1 + lat;
        exp_q.push_back(e);
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic issue_ref(input logic [31:0] a, input logic [31:0] b, input logic rc);
        logic [31:0] q;
        logic [1:0]  code;
        int          lat;
        ref_div(a, b, rc, q, code, lat);
        issue(a, b, rc, q, code, lat);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 200) begin
            @(negedge sys_clk);
            #1;
            g++;
        end
        if (exp_q.size() > 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int          sel;
        sel = $urandom_range(0, 15);
        f   = 23'($urandom);
        case (sel)
            0:       e = 8'd0;
            1:       begin e = 8'hFF; f = 23'd0; end
            2:       e = 8'hFF;
            3:       e = 8'd1;
            4:       e = 8'd254;
            5:       begin e = 8'($urandom_range(100, 154)); f = 23'd0; end
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, f};
    endfunction

    // Monitor: every done pulse retires the oldest expected result
    always @(negedge sys_clk) begin
        if (!sys_rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("float_q", 64'(float_q), 64'(mon_e.q));
                check("overflow", 64'(overflow), 64'(mon_e.code));
                check("done_cycle", 64'(cycle), 64'(mon_e.cyc));
                check("busy_with_done", 64'(busy), 64'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst     = 1'b1;
        start       = 1'b0;
        float_a     = 32'h0;
        float_b     = 32'h0;
        round_cofig = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_float_q", 64'(float_q), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        sys_rst = 1'b0;

        // Directed cases, issued back to back
        issue(32'h40B33333, 32'h40066666, 1'b0, 32'h402AAAAB, 2'b00, 29);
        issue(32'h40B33333, 32'h40066666, 1'b1, 32'h402AAAAA, 2'b00, 29);
        issue(32'h40C00000, 32'h40000000, 1'b0, 32'h40400000, 2'b00, 29);
        issue(32'hBF800000, 32'h40400000, 1'b0, 32'hBEAAAAAB, 2'b00, 29);
        issue(32'hBF800000, 32'h40400000, 1'b1, 32'hBEAAAAAA, 2'b00, 29);
        issue(32'h3F800000, 32'h00000000, 1'b0, 32'h7F800000, 2'b11, 1);
        issue(32'h00000000, 32'h00000000, 1'b0, 32'h7FC00000, 2'b11, 1);
        issue(32'h7F800000, 32'h40000000, 1'b0, 32'h7F800000, 2'b01, 1);
        issue(32'h40000000, 32'h7F800000, 1'b0, 32'h00000000, 2'b00, 1);
        issue(32'h7F000000, 32'h00800000, 1'b0, 32'h7F800000, 2'b01, 29);
        issue(32'h00800000, 32'h7F000000, 1'b0, 32'h00000000, 2'b10, 29);
        wait_drain();

        // Start and rounding change during DIV must not disturb the running op
        issue(32'h40B33333, 32'h40066666, 1'b0, 32'h402AAAAB, 2'b00, 29);
        repeat (4) @(negedge sys_clk);
        float_a     = 32'h3F800000;
        float_b     = 32'h00000000;
        round_cofig = 1'b1;
        start       = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        wait_drain();

        // Reset at iteration 10 discards the in-flight result
        issue(32'h40B33333, 32'h40066666, 1'b0, 32'h402AAAAB, 2'b00, 29);
        repeat (9) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_float_q", 64'(float_q), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        void'(exp_q.pop_back());
        #1 sys_rst = 1'b0;
        repeat (35) @(negedge sys_clk);
        issue(32'h40C00000, 32'h40000000, 1'b0, 32'h40400000, 2'b00, 29);
        wait_drain();

        for (int i = 0; i < 60; i++) begin
            issue_ref(rand_op(), rand_op(), 1'($urandom));
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
